// File: rtl/ysyx_23060332_wb_arbiter_if.sv
// ----------------------------------------------------------------------------
// ysyx_23060332_wb_arbiter_if
//
// Purpose:
//   Bundles every handshake and data signal around the write-back arbiter
//   into a single interface. Clock and reset stay outside as plain ports.
//
// Signal summary:
//   exu_*/lsu_*/csr_*  valid/ready handshake, destination address, write data
//                      of the three write-back sources
//   issue_*            IDU issue strobe, rd write flag, rd, rs1 and rs2
//   stall              IDU hold request (combinational)
//   reg_wen/waddr/wdata registered register-file write port
//   sb_err             sticky flag: a commit hit a register that was not busy
//
// Modports:
//   master  the environment side (sources, IDU, register file)
//   slave   the arbiter/scoreboard side
// ----------------------------------------------------------------------------
interface ysyx_23060332_wb_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);

    logic              exu_valid;
    logic              exu_ready;
    logic [ADDR_W-1:0] exu_waddr;
    logic [DATA_W-1:0] exu_wdata;

    logic              lsu_valid;
    logic              lsu_ready;
    logic [ADDR_W-1:0] lsu_waddr;
    logic [DATA_W-1:0] lsu_wdata;

    logic              csr_valid;
    logic              csr_ready;
    logic [ADDR_W-1:0] csr_waddr;
    logic [DATA_W-1:0] csr_wdata;

    logic              issue_valid;
    logic              issue_wen;
    logic [ADDR_W-1:0] issue_rd;
    logic [ADDR_W-1:0] issue_rs1;
    logic [ADDR_W-1:0] issue_rs2;
    logic              stall;

    logic              reg_wen;
    logic [ADDR_W-1:0] reg_waddr;
    logic [DATA_W-1:0] reg_wdata;
    logic              sb_err;

    modport master (
        output exu_valid, exu_waddr, exu_wdata,
        output lsu_valid, lsu_waddr, lsu_wdata,
        output csr_valid, csr_waddr, csr_wdata,
        output issue_valid, issue_wen, issue_rd, issue_rs1, issue_rs2,
        input  exu_ready, lsu_ready, csr_ready,
        input  stall,
        input  reg_wen, reg_waddr, reg_wdata,
        input  sb_err
    );

    modport slave (
        input  exu_valid, exu_waddr, exu_wdata,
        input  lsu_valid, lsu_waddr, lsu_wdata,
        input  csr_valid, csr_waddr, csr_wdata,
        input  issue_valid, issue_wen, issue_rd, issue_rs1, issue_rs2,
        output exu_ready, lsu_ready, csr_ready,
        output stall,
        output reg_wen, reg_waddr, reg_wdata,
        output sb_err
    );

endinterface

// File: rtl/ysyx_23060332_wb_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_23060332_wb_arbiter
//
// Purpose:
//   Write-back arbiter and busy scoreboard for the integer register file
//   (one write port, two read ports). EXU, LSU and CSR compete for the write
//   port under round-robin arbitration; the winner is captured into a single
//   output register stage that drives the register file. A per-register busy
//   vector is set when the IDU issues a writing instruction and cleared when
//   the register file is written, and it produces the IDU stall for RAW and
//   WAW hazards.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-low reset
//   bus   slave modport of ysyx_23060332_wb_arbiter_if (handshakes, issue
//         information, register-file write port, stall, sb_err)
// ----------------------------------------------------------------------------
module ysyx_23060332_wb_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    ysyx_23060332_wb_arbiter_if.slave    bus
);

    localparam int NREG = 1 << ADDR_W;

    // Source indices in round-robin order.
    localparam logic [1:0] SRC_EXU = 2'd0;
    localparam logic [1:0] SRC_LSU = 2'd1;
    localparam logic [1:0] SRC_CSR = 2'd2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]        ptr_q,       ptr_d;
    logic              reg_wen_q,   reg_wen_d;
    logic [ADDR_W-1:0] reg_waddr_q, reg_waddr_d;
    logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
    logic [NREG-1:0]   busy_q,      busy_d;
    logic              sb_err_q,    sb_err_d;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    logic [2:0]        valid_vec;
    logic [2:0]        grant;
    logic [1:0]        grant_idx;
    logic              fire;
    logic [ADDR_W-1:0] sel_waddr;
    logic [DATA_W-1:0] sel_wdata;

    assign valid_vec = {bus.csr_valid, bus.lsu_valid, bus.exu_valid};
    assign fire      = |valid_vec;

    // The search begins one past the last granted source. Pointer value 3 is
    // unreachable; it is folded into the "last was CSR" case so the arbiter
    // still behaves sanely should it ever appear.
    always_comb begin
        grant_idx = ptr_q;
        case (ptr_q)
            SRC_EXU: begin
                if      (valid_vec[SRC_LSU]) grant_idx = SRC_LSU;
                else if (valid_vec[SRC_CSR]) grant_idx = SRC_CSR;
                else if (valid_vec[SRC_EXU]) grant_idx = SRC_EXU;
            end
            SRC_LSU: begin
                if      (valid_vec[SRC_CSR]) grant_idx = SRC_CSR;
                else if (valid_vec[SRC_EXU]) grant_idx = SRC_EXU;
                else if (valid_vec[SRC_LSU]) grant_idx = SRC_LSU;
            end
            default: begin
                if      (valid_vec[SRC_EXU]) grant_idx = SRC_EXU;
                else if (valid_vec[SRC_LSU]) grant_idx = SRC_LSU;
                else if (valid_vec[SRC_CSR]) grant_idx = SRC_CSR;
            end
        endcase
    end

    // One-hot grant; all zero when nobody is requesting.
    assign grant = fire ? (3'b001 << grant_idx) : 3'b000;

    assign bus.exu_ready = grant[SRC_EXU];
    assign bus.lsu_ready = grant[SRC_LSU];
    assign bus.csr_ready = grant[SRC_CSR];

    // Address/data of the winning source.
    always_comb begin
        sel_waddr = bus.exu_waddr;
        sel_wdata = bus.exu_wdata;
        case (grant_idx)
            SRC_LSU: begin
                sel_waddr = bus.lsu_waddr;
                sel_wdata = bus.lsu_wdata;
            end
            SRC_CSR: begin
                sel_waddr = bus.csr_waddr;
                sel_wdata = bus.csr_wdata;
            end
            default: begin
                sel_waddr = bus.exu_waddr;
                sel_wdata = bus.exu_wdata;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Pointer and output stage next state
    // ------------------------------------------------------------------------
    // x0 writes are still accepted (the source must see its handshake
    // complete) but never raise the register-file write enable.
    always_comb begin
        ptr_d       = ptr_q;
        reg_wen_d   = 1'b0;
        reg_waddr_d = reg_waddr_q;
        reg_wdata_d = reg_wdata_q;
        if (fire) begin
            ptr_d       = grant_idx;
            reg_wen_d   = (sel_waddr != '0);
            reg_waddr_d = sel_waddr;
            reg_wdata_d = sel_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------------
    logic issue_set;
    logic commit_bad;

    // A stalled issue is not an issue, so it must not mark rd busy.
    assign issue_set = bus.issue_valid && bus.issue_wen && !bus.stall &&
                       (bus.issue_rd != '0);

    // Busy bits clear on the same edge the register file is written, which is
    // the edge where the output stage holds reg_wen=1. The set is applied
    // after the clear so a same-index collision leaves the bit set.
    always_comb begin
        busy_d = busy_q;
        if (reg_wen_q) begin
            busy_d[reg_waddr_q] = 1'b0;
        end
        if (issue_set) begin
            busy_d[bus.issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // A commit to a register nobody marked busy indicates a lost or duplicated
    // write-back; latch it until reset.
    assign commit_bad = reg_wen_q && (reg_waddr_q != '0) && !busy_q[reg_waddr_q];

    always_comb begin
        sb_err_d = sb_err_q | commit_bad;
    end

    // There is no bypass, so any pending writer of a source or of rd holds
    // the IDU. busy_q[0] is always 0, which keeps x0 from ever stalling.
    assign bus.stall = bus.issue_valid &&
                       (busy_q[bus.issue_rs1] ||
                        busy_q[bus.issue_rs2] ||
                        (bus.issue_wen && busy_q[bus.issue_rd]));

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // Reset drops any write sitting in the output stage and returns the
    // pointer to CSR so EXU has first priority afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q       <= SRC_CSR;
            reg_wen_q   <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
            busy_q      <= '0;
            sb_err_q    <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            reg_wen_q   <= reg_wen_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
            busy_q      <= busy_d;
            sb_err_q    <= sb_err_d;
        end
    end

    assign bus.reg_wen   = reg_wen_q;
    assign bus.reg_waddr = reg_waddr_q;
    assign bus.reg_wdata = reg_wdata_q;
    assign bus.sb_err    = sb_err_q;

endmodule
